ddr_write_arbiter: RTL and testbench



---
 rtl/ddr_arb_pkg.sv | 31 +++
 rtl/axis_skid_buffer.sv | 52 +++++
 rtl/ddr_write_arbiter.sv | 132 +++++++++++++
 tb/tb_ddr_write_arbiter.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_arb_pkg.sv
// Shared types and helpers for the DDR write-side arbiter.
// Holds the FSM state type, the FIFO data width and the round-robin picker.
package ddr_arb_pkg;

    typedef enum logic [0:0] {IDLE, PASS} arb_state_t;

    localparam int unsigned DDR_AXIS_WIDTH = 128;
    localparam int unsigned MAX_REQ        = 8;

    // First set bit of valid at or above ptr, wrapping within num_req; one-hot result.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                                   input logic [2:0]         ptr,
                                                   input int unsigned        num_req);
        logic [MAX_REQ-1:0] pick;
        logic [2:0]         idx;
        logic               found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_REQ; i++) begin
            if (i < num_req) begin
                idx = 3'((32'(ptr) + i) % num_req);
                if (!found && valid[idx]) begin
                    pick[idx] = 1'b1;
                    found     = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry registered skid buffer; input ready depends only on stored occupancy.
// Output data comes straight from storage, so it holds steady while stalled.
module axis_skid_buffer #(
    parameter int unsigned Width = 129
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [Width-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [Width-1:0] out_data_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             push, pop;

    assign in_ready_o  = (count_q != 2'd2);
    assign out_valid_o = (count_q != 2'd0);
    assign out_data_o  = mem_q[rd_ptr_q];
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = ~wr_ptr_q;
        if (pop)  rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) mem_q[wr_ptr_q] <= in_data_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ddr_write_arbiter.sv
// Packet-granular round-robin arbiter feeding the sender side of the DDR CDC FIFO.
// A grant is held until tlast (real or forced at MAX_BURST) has been accepted.
module ddr_write_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = DDR_AXIS_WIDTH,
    parameter int unsigned MAX_BURST  = 64
) (
    input  logic                          sender_clk,
    input  logic                          sender_aresetn,
    input  logic [NUM_REQ-1:0]            req_axis_tvalid,
    output logic [NUM_REQ-1:0]            req_axis_tready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_axis_tdata,
    input  logic [NUM_REQ-1:0]            req_axis_tlast,
    output logic                          fifo_axis_tvalid,
    input  logic                          fifo_axis_tready,
    output logic [DATA_WIDTH-1:0]         fifo_axis_tdata,
    output logic                          fifo_axis_tlast,
    input  logic                          fifo_prog_full,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy,
    output logic                          overrun_err
);

    localparam int unsigned PtrW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST);

    arb_state_t            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CntW-1:0]       beat_cnt_q, beat_cnt_d;
    logic                  overrun_q, overrun_d;

    logic [PtrW-1:0]       g_idx, next_ptr;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  g_last, g_valid;
    logic                  force_last, skid_in_valid, skid_in_ready, skid_in_last, accept;
    logic [MAX_REQ-1:0]    pick_full;
    logic [DATA_WIDTH:0]   skid_out;

    // Mux the owning requester's stream; grant_q is one-hot or zero.
    always_comb begin
        g_idx   = '0;
        g_data  = '0;
        g_last  = 1'b0;
        g_valid = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                g_idx   = PtrW'(i);
                g_data  = req_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                g_last  = req_axis_tlast[i];
                g_valid = req_axis_tvalid[i];
            end
        end
    end

    assign force_last    = (beat_cnt_q == CntW'(MAX_BURST - 1));
    assign skid_in_valid = (state_q == PASS) && g_valid;
    assign skid_in_last  = g_last || force_last;
    assign accept        = skid_in_valid && skid_in_ready;
    assign next_ptr      = (g_idx == PtrW'(NUM_REQ - 1)) ? '0 : g_idx + PtrW'(1);
    assign pick_full     = rr_pick(MAX_REQ'(req_axis_tvalid), 3'(rr_ptr_q), NUM_REQ);

    always_comb begin
        state_d         = state_q;
        grant_d         = grant_q;
        rr_ptr_d        = rr_ptr_q;
        beat_cnt_d      = beat_cnt_q;
        overrun_d       = overrun_q;
        req_axis_tready = '0;
        case (state_q)
            IDLE: begin
                if (|req_axis_tvalid && !fifo_prog_full && skid_in_ready) begin
                    state_d    = PASS;
                    grant_d    = pick_full[NUM_REQ-1:0];
                    beat_cnt_d = '0;
                end
            end
            PASS: begin
                req_axis_tready = grant_q & {NUM_REQ{skid_in_ready}};
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CntW'(1);
                    if (skid_in_last) begin
                        state_d    = IDLE;
                        grant_d    = '0;
                        rr_ptr_d   = next_ptr;
                        beat_cnt_d = '0;
                        if (force_last && !g_last) overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sender_clk or negedge sender_aresetn) begin
        if (!sender_aresetn) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
            overrun_q  <= overrun_d;
        end
    end

    axis_skid_buffer #(
        .Width(DATA_WIDTH + 1)
    ) u_skid (
        .clk_i      (sender_clk),
        .rst_ni     (sender_aresetn),
        .in_valid_i (skid_in_valid),
        .in_ready_o (skid_in_ready),
        .in_data_i  ({g_data, skid_in_last}),
        .out_valid_o(fifo_axis_tvalid),
        .out_ready_i(fifo_axis_tready),
        .out_data_o (skid_out)
    );

    assign fifo_axis_tdata = skid_out[DATA_WIDTH:1];
    assign fifo_axis_tlast = skid_out[0];
    assign grant           = grant_q;
    assign busy            = (state_q == PASS);
    assign overrun_err     = overrun_q;

endmodule

// File: tb/tb_ddr_write_arbiter.sv
// Scoreboard bench for ddr_write_arbiter: drivers push expected beats per requester,
// a monitor pops and compares every beat the FIFO side accepts.
module tb_ddr_write_arbiter;

    localparam int NR = 4;
    localparam int DW = 128;
    localparam int MB = 64;

    logic             clk;
    logic             rst_n;
    logic [NR-1:0]    req_axis_tvalid, req_axis_tready, req_axis_tlast;
    logic [NR*DW-1:0] req_axis_tdata;
    logic             fifo_axis_tvalid, fifo_axis_tready, fifo_axis_tlast, fifo_prog_full;
    logic [DW-1:0]    fifo_axis_tdata;
    logic [NR-1:0]    grant;
    logic             busy, overrun_err;

    logic          tv [NR];
    logic [DW-1:0] td [NR];
    logic          tl [NR];
    bit            done [NR];
    bit            abort, rand_rdy;
    logic          fixed_rdy, rnd_rdy;
    int            tests, fails;
    logic [DW:0]   exp_q [NR][$];
    int            order_q [$];

    ddr_write_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .sender_clk      (clk),
        .sender_aresetn  (rst_n),
        .req_axis_tvalid (req_axis_tvalid),
        .req_axis_tready (req_axis_tready),
        .req_axis_tdata  (req_axis_tdata),
        .req_axis_tlast  (req_axis_tlast),
        .fifo_axis_tvalid(fifo_axis_tvalid),
        .fifo_axis_tready(fifo_axis_tready),
        .fifo_axis_tdata (fifo_axis_tdata),
        .fifo_axis_tlast (fifo_axis_tlast),
        .fifo_prog_full  (fifo_prog_full),
        .grant           (grant),
        .busy            (busy),
        .overrun_err     (overrun_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        for (int i = 0; i < NR; i++) begin
            req_axis_tvalid[i]          = tv[i];
            req_axis_tlast[i]           = tl[i];
            req_axis_tdata[i*DW +: DW]  = td[i];
        end
    end

    assign fifo_axis_tready = rand_rdy ? rnd_rdy : fixed_rdy;

    function automatic logic [DW-1:0] mk(input int r, input int v);
        logic [DW-1:0] d;
        d = '0;
        d[DW-1 -: 8] = 8'(r);
        d[31:0]      = 32'(v);
        return d;
    endfunction

    task automatic check(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one packet; the expected stream (with tlast forced every MB beats) is queued
    // as each beat is offered.
    task automatic send_pkt(input int r, input int n, input int base, input bit last,
                            input int gap_pct);
        int   pb;
        int   wc;
        logic el;
        pb = 0;
        @(posedge clk); #1;
        for (int i = 0; i < n; i++) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                tv[r] = 1'b0;
                repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
            end
            el    = (last && i == n - 1) || (pb == MB - 1);
            tv[r] = 1'b1;
            td[r] = mk(r, base + i);
            tl[r] = last && (i == n - 1);
            exp_q[r].push_back({mk(r, base + i), el});
            pb = el ? 0 : pb + 1;
            wc = 0;
            forever begin
                @(negedge clk);
                if (abort) begin
                    tv[r] = 1'b0; tl[r] = 1'b0; done[r] = 1'b1;
                    return;
                end
                if (req_axis_tready[r]) break;
                wc++;
                if (wc > 3000) begin
                    tests++; fails++;
                    $display("FAIL handshake_timeout req%0d beat%0d: waited %0d cycles, limit 3000",
                             r, i, wc);
                    tv[r] = 1'b0; tl[r] = 1'b0; done[r] = 1'b1;
                    return;
                end
            end
            @(posedge clk); #1;
        end
        tv[r] = 1'b0;
        tl[r] = 1'b0;
        done[r] = 1'b1;
    endtask

    task automatic launch(input int r, input int n, input int base, input bit last,
                          input int gap_pct);
        done[r] = 1'b0;
        fork
            send_pkt(r, n, base, last, gap_pct);
        join_none
    endtask

    task automatic rand_stream(input int r);
        for (int p = 0; p < 250; p++) begin
            done[r] = 1'b0;
            send_pkt(r, int'($urandom_range(1, 8)), p * 16, 1'b1, 25);
        end
    endtask

    task automatic wait_done(input int r);
        int c;
        c = 0;
        while (!done[r] && c < 5000) begin @(negedge clk); c++; end
        if (!done[r]) @(negedge clk);
        check($sformatf("done_req%0d", r), done[r], 1);
    endtask

    task automatic wait_busy();
        int c;
        c = 0;
        while (!busy && c < 200) begin @(negedge clk); c++; end
        check("busy_seen", busy, 1);
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int r = 0; r < NR; r++) s += exp_q[r].size();
        return s + (fifo_axis_tvalid ? 1 : 0);
    endfunction

    task automatic drain();
        int c;
        c = 0;
        while (pending() != 0 && c < 5000) begin @(negedge clk); c++; end
        check("drain_pending", pending(), 0);
    endtask

    task automatic check_order(input string name, input int n, input int e0, input int e1,
                               input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        check({name, "_len"}, order_q.size(), n);
        for (int i = 0; i < n && i < order_q.size(); i++)
            check($sformatf("%s_%0d", name, i), order_q[i], e[i]);
        order_q.delete();
    endtask

    task automatic monitor();
        bit          in_pkt, prev_stall;
        int          cur_id, id;
        logic [DW:0] prev_word, e;
        in_pkt = 0; prev_stall = 0; cur_id = 0; prev_word = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                in_pkt = 0; prev_stall = 0;
                continue;
            end
            if (prev_stall) begin
                check("stall_valid", fifo_axis_tvalid, 1);
                check("stall_data", {fifo_axis_tdata, fifo_axis_tlast}, prev_word);
            end
            if (fifo_axis_tvalid && fifo_axis_tready) begin
                id = int'(fifo_axis_tdata[DW-1 -: 8]);
                if (id >= NR) begin
                    tests++; fails++;
                    $display("FAIL beat_tag: got requester %0d, expected below %0d", id, NR);
                end else if (exp_q[id].size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_beat: got %h, expected none pending",
                             fifo_axis_tdata);
                end else begin
                    e = exp_q[id].pop_front();
                    check($sformatf("beat_req%0d", id), {fifo_axis_tdata, fifo_axis_tlast}, e);
                end
                if (in_pkt) check("no_interleave", id, cur_id);
                in_pkt = !fifo_axis_tlast;
                cur_id = id;
                if (fifo_axis_tlast) order_q.push_back(id);
            end
            prev_stall = fifo_axis_tvalid && !fifo_axis_tready;
            prev_word  = {fifo_axis_tdata, fifo_axis_tlast};
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, fifo_axis_tvalid, 0);
        check({tag, "_tdata"}, fifo_axis_tdata, 0);
        check({tag, "_tlast"}, fifo_axis_tlast, 0);
        check({tag, "_grant"}, grant, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overrun"}, overrun_err, 0);
        check({tag, "_req_tready"}, req_axis_tready, 0);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; fifo_prog_full = 1'b0; fixed_rdy = 1'b1; rand_rdy = 1'b0;
        rnd_rdy = 1'b0; abort = 1'b0; tests = 0; fails = 0;
        for (int r = 0; r < NR; r++) begin
            tv[r] = 1'b0; td[r] = '0; tl[r] = 1'b0; done[r] = 1'b1;
        end
        fork
            monitor();
            forever begin @(posedge clk); #1 rnd_rdy = 1'($urandom_range(0, 1)); end
        join_none

        repeat (3) @(posedge clk); #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single requester, 4 beats.
        launch(0, 4, 1, 1'b1, 0);
        wait_busy();
        check("t1_grant", grant, 4'b0001);
        wait_done(0);
        check("t1_grant_idle", grant, 0);
        check("t1_busy_idle", busy, 0);
        drain();
        check_order("t1_order", 1, 0, 0, 0, 0);

        // All four contend from rr_ptr = 0.
        pulse_reset();
        for (int r = 0; r < NR; r++) launch(r, 2, 16 * r, 1'b1, 0);
        for (int r = 0; r < NR; r++) wait_done(r);
        drain();
        check_order("t2_order_a", 4, 0, 1, 2, 3);

        // Single-beat packet from requester 1 moves rr_ptr to 2.
        launch(1, 1, 'h50, 1'b1, 0);
        wait_busy();
        wait_done(1);
        check("t2_single_busy", busy, 0);
        check("t2_single_grant", grant, 0);
        drain();
        check_order("t2_single", 1, 1, 0, 0, 0);

        for (int r = 0; r < NR; r++) launch(r, 2, 'h80 + 16 * r, 1'b1, 0);
        for (int r = 0; r < NR; r++) wait_done(r);
        drain();
        check_order("t2_order_b", 4, 2, 3, 0, 1);

        // prog_full blocks new grants only.
        fifo_prog_full = 1'b1;
        launch(1, 3, 'h60, 1'b1, 0);
        repeat (20) begin
            @(negedge clk);
            check("t3_pf_grant", grant, 0);
            check("t3_pf_tready", req_axis_tready, 0);
        end
        @(posedge clk); #1 fifo_prog_full = 1'b0;
        @(posedge clk); #1;
        check("t3_grant_after_pf", grant, 4'b0010);
        wait_done(1);
        drain();
        launch(0, 6, 'h70, 1'b1, 0);
        wait_busy();
        @(posedge clk); #1 fifo_prog_full = 1'b1;
        wait_done(0);
        launch(3, 1, 'h90, 1'b1, 0);
        repeat (5) begin
            @(negedge clk);
            check("t3_pf2_grant", grant, 0);
        end
        @(posedge clk); #1 fifo_prog_full = 1'b0;
        wait_done(3);
        drain();
        check_order("t3_order", 3, 1, 0, 3, 0);

        // 70 beats with no tlast: forced tlast on beat 64.
        check("t4_overrun_before", overrun_err, 0);
        launch(2, 70, 'h1000, 1'b0, 0);
        wait_done(2);
        @(negedge clk);
        check("t4_overrun", overrun_err, 1);
        check("t4_grant_held", grant, 4'b0100);
        check("t4_busy_held", busy, 1);
        drain();
        check_order("t4_order", 1, 2, 0, 0, 0);
        pulse_reset();
        check("t4_overrun_cleared", overrun_err, 0);

        // Random backpressure, random gaps, 1000 packets.
        rand_rdy = 1'b1;
        fork
            rand_stream(0);
            rand_stream(1);
            rand_stream(2);
            rand_stream(3);
        join
        rand_rdy = 1'b0;
        drain();
        check("t5_packets", order_q.size(), 1000);
        order_q.delete();

        // Reset in the middle of beat 3 of 5.
        launch(0, 5, 'h200, 1'b1, 0);
        wait_busy();
        @(posedge clk);
        @(posedge clk);
        #3 rst_n = 1'b0;
        abort = 1'b1;
        #1;
        check_reset_outputs("midreset");
        wait_done(0);
        for (int r = 0; r < NR; r++) exp_q[r].delete();
        order_q.delete();
        abort = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        launch(3, 3, 'h300, 1'b1, 0);
        wait_done(3);
        drain();
        check_order("t6_order", 1, 3, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
